adc_read_ctrl: RTL and testbench
================================

ADC_READ_CTRL -- requirements
Module: adc_read_ctrl

Interface
REQ-001 Parameter DIV, default 4: clk_i cycles per dclk half-period; legal range 2..255.
REQ-002 Parameter NCYC, default 25: dclk cycles per ADC frame; the first cycle is a status bit, the rest are data.
REQ-003 Parameter TMO, default 1024: ready-wait timeout in clk_i cycles (used only under ADC_DRDY_EN).
REQ-004 clk_i  input  1  system clock, rising-edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  conversion-read request, sampled in IDLE only.
REQ-007 miso_i  input  1  ADC serial data out (also EOC/ready when ADC_DRDY_EN).
REQ-008 cs_o  output  1  ADC chip select, active-low.
REQ-009 dclk_o  output  1  ADC serial clock, idles low.
REQ-010 data_o  output  NCYC-1 (24)  last captured sample, MSB first on the wire.
REQ-011 valid_o  output  1  one-cycle pulse, data_o updated.
REQ-012 busy_o  output  1  frame in progress.
REQ-013 err_o  output  1  one-cycle pulse on ready timeout; tied 0 without ADC_DRDY_EN.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, [WAIT_RDY], CLK_LO, CLK_HI, DONE; all outputs registered.
REQ-015 IDLE: cs_o=1, dclk_o=0, busy_o=0; start_i=1 at an edge -> SETUP, cs_o=0 and busy_o=1 from that edge.
REQ-016 SETUP lasts DIV cycles (CS-to-dclk setup), then -> CLK_LO (or WAIT_RDY under macro).
REQ-017 CLK_LO: dclk_o=0 for DIV cycles -> CLK_HI; CLK_HI: dclk_o=1 for DIV cycles.
REQ-018 miso_i SHALL be sampled on the clk_i edge that enters CLK_HI (dclk rising edge).
REQ-019 Bit 0 of the frame (status) is discarded; bits 1..NCYC-1 shift into an internal register, MSB first.
REQ-020 Internal cycle counter, width 5, clears on SETUP entry, increments at each CLK_HI exit; at count NCYC -> DONE, else -> CLK_LO.
REQ-021 DONE (one cycle): cs_o=1, dclk_o=0, data_o loaded from shift register, valid_o=1; next cycle -> IDLE, busy_o=0.
REQ-022 Latency: valid_o high exactly DIV + 2*DIV*NCYC + 1 cycles after the start edge (DIV=4, NCYC=25: 205).
REQ-023 start_i asserted while busy_o=1 SHALL be ignored, not queued; start_i held high re-triggers from IDLE after DONE.
REQ-024 data_o SHALL hold its value between frames and change only in DONE.
REQ-025 Divider counter SHALL wrap to 0 on every state change; no dclk phase shorter than DIV cycles.

Reset
REQ-026 rst_i=1 at any time (including mid-frame) SHALL force IDLE: cs_o=1, dclk_o=0, busy_o=0, valid_o=0, err_o=0, data_o=0, all counters 0.
REQ-027 A frame aborted by reset SHALL NOT produce valid_o after reset release.

Configuration
REQ-028 Macro ADC_DRDY_EN: when defined, SETUP -> WAIT_RDY; dclk_o stays 0 until miso_i=0 (ADC ready), then -> CLK_LO.
REQ-029 With ADC_DRDY_EN, if miso_i stays 1 for TMO cycles in WAIT_RDY: cs_o=1, err_o pulses one cycle, -> IDLE, data_o unchanged, no valid_o.
REQ-030 Without ADC_DRDY_EN: WAIT_RDY state and timeout counter absent, err_o constant 0, REQ-022 latency exact.

Verification
REQ-031 DIV=4, start pulse, miso_i driven status 1 then 0xA5C3F0 -> valid_o at cycle 205, data_o=0xA5C3F0, exactly 25 dclk pulses.
REQ-032 start_i held high for 300 cycles -> two frames back to back, second start accepted cycle after DONE, no extra start during frame.
REQ-033 rst_i asserted at dclk pulse 12 -> cs_o=1, dclk_o=0, data_o=0 immediately; no valid_o afterwards.
REQ-034 miso_i constant 1 (no macro) -> data_o=0xFFFFFF; constant 0 -> data_o=0x000000.
REQ-035 ADC_DRDY_EN, miso_i=1 for 1024 cycles -> err_o pulse, cs_o=1, no dclk pulses, data_o unchanged.
REQ-036 ADC_DRDY_EN, miso_i goes low 50 cycles after SETUP -> first dclk rise DIV cycles later, normal capture.

Source files
------------

// File: rtl/adc_read_ctrl.sv
// Serial ADC frame reader: drives cs/dclk, discards the status bit, and captures NCYC-1 data bits MSB first.
// Optional macro ADC_DRDY_EN adds a ready-wait (miso low) with timeout between SETUP and clocking.
module adc_read_ctrl #(
  parameter int DIV  = 4,
  parameter int NCYC = 25,
  parameter int TMO  = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            miso_i,
  output logic            cs_o,
  output logic            dclk_o,
  output logic [NCYC-2:0] data_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int DW = NCYC - 1;
  localparam int CW = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
`ifdef ADC_DRDY_EN
    WAIT_RDY,
`endif
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

  state_t          state, next_state;
  logic [7:0]      div_cnt;
  logic [CW-1:0]   cyc_cnt;
  logic [DW-1:0]   shreg;
  logic            div_last;
  logic            last_bit;
  logic            cs_d, dclk_d, busy_d, valid_d;

  assign div_last = (div_cnt == 8'(DIV - 1));
  assign last_bit = (cyc_cnt == CW'(NCYC - 1));

`ifdef ADC_DRDY_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_last;
  logic          err_d;

  assign tmo_last = (tmo_cnt == TW'(TMO - 1));
  assign err_d    = (state == WAIT_RDY) && miso_i && tmo_last;
`else
  assign err_o = 1'b0;
`endif

  // NOTE: outputs are registered from next_state so they switch on the same edge as the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cs_o    <= 1'b1;
      dclk_o  <= 1'b0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state   <= next_state;
      cs_o    <= cs_d;
      dclk_o  <= dclk_d;
      busy_o  <= busy_d;
      valid_o <= valid_d;
    end
  end

  // NOTE: next_state is defaulted to state first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (start_i) next_state = SETUP;
`ifdef ADC_DRDY_EN
      SETUP:    if (div_last) next_state = WAIT_RDY;
      WAIT_RDY: if (!miso_i) next_state = CLK_LO;
                else if (tmo_last) next_state = IDLE;
`else
      SETUP:    if (div_last) next_state = CLK_LO;
`endif
      CLK_LO:   if (div_last) next_state = CLK_HI;
      CLK_HI:   if (div_last) next_state = last_bit ? DONE : CLK_LO;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    cs_d    = 1'b1;
    dclk_d  = 1'b0;
    busy_d  = (next_state != IDLE);
    valid_d = (next_state == DONE);
    case (next_state)
      IDLE, DONE: cs_d = 1'b1;
      CLK_HI: begin
        cs_d   = 1'b0;
        dclk_d = 1'b1;
      end
      default:    cs_d = 1'b0;
    endcase
  end

  // Divider restarts on every state change so each dclk phase is a full DIV cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      cyc_cnt <= '0;
      shreg   <= '0;
      data_o  <= '0;
    end else begin
      if (state == IDLE || next_state != state) div_cnt <= '0;
      else                                      div_cnt <= div_cnt + 8'd1;

      if (state == IDLE && next_state == SETUP)  cyc_cnt <= '0;
      else if (state == CLK_HI && div_last)      cyc_cnt <= cyc_cnt + CW'(1);

      // miso is taken on the edge that raises dclk; bit 0 is the status bit.
      if (state == CLK_LO && div_last && cyc_cnt != '0)
        shreg <= {shreg[DW-2:0], miso_i};

      if (next_state == DONE) data_o <= shreg;
    end
  end

`ifdef ADC_DRDY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      err_o <= err_d;
      if (state == WAIT_RDY && next_state == WAIT_RDY) tmo_cnt <= tmo_cnt + TW'(1);
      else                                             tmo_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_adc_read_ctrl.sv
// Directed bench for adc_read_ctrl (DIV=4, NCYC=25): frame vectors table plus reset-abort,
// back-to-back and, when ADC_DRDY_EN is defined, ready/timeout sequences.
module tb_adc_read_ctrl;

  localparam int LAT = 205;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        miso_i = 1'b0;
  logic        cs_o, dclk_o, valid_o, busy_o, err_o;
  logic [23:0] data_o;

  logic [24:0] cur_frame = '0;
  logic        manual = 1'b0;
  logic        miso_man = 1'b0;
  int          d_rises = 0;
  logic        d_prev = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [24:0] frame;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  adc_read_ctrl #(.DIV(4), .NCYC(25), .TMO(1024)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .miso_i (miso_i),
    .cs_o   (cs_o),
    .dclk_o (dclk_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  // ADC model: presents the next frame bit after each dclk rise, status bit first.
  always begin
    @(negedge clk_i);
    #1;
    if (cs_o) d_rises = 0;
    else if (dclk_o && !d_prev) d_rises = d_rises + 1;
    d_prev = dclk_o;
    if (manual)            miso_i = miso_man;
    else if (d_rises < 25) miso_i = cur_frame[24 - d_rises];
    else                   miso_i = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [24:0] f, output int lat, output int pulses,
                           output logic [23:0] mid);
    logic prev_d;
    cur_frame = f;
    manual    = 1'b0;
    lat       = -1;
    pulses    = 0;
    mid       = '0;
    prev_d    = 1'b0;
    start_i   = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk_i);
      if (dclk_o && !prev_d) pulses++;
      prev_d = dclk_o;
      if (c == 100) mid = data_o;
      if (valid_o) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int          lat, pulses, rises, valids, falls, second_cyc, errs, err_cyc, first_rise;
    int          v1_cyc, v2_cyc;
    logic [23:0] mid, prev_data, v2_data;
    logic        prev_cs, prev_d, hit;

    repeat (3) @(negedge clk_i);
    check("reset_cs",    32'(cs_o),    32'h1);
    check("reset_dclk",  32'(dclk_o),  32'h0);
    check("reset_busy",  32'(busy_o),  32'h0);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_err",   32'(err_o),   32'h0);
    check("reset_data",  32'(data_o),  32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

`ifndef ADC_DRDY_EN
    vecs[0] = '{25'h1A5C3F0, 24'hA5C3F0};
    vecs[1] = '{25'h1FFFFFF, 24'hFFFFFF};
    vecs[2] = '{25'h0000000, 24'h000000};
    vecs[3] = '{25'h05A5A5A, 24'h5A5A5A};
    vecs[4] = '{25'h1800001, 24'h800001};
    prev_data = '0;
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].frame, lat, pulses, mid);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("v%0d_data", i), 32'(data_o), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_pulses", i), 32'(pulses), 32'd25);
      check($sformatf("v%0d_hold", i), 32'(mid), 32'(prev_data));
      @(negedge clk_i);
      check($sformatf("v%0d_valid_1cyc", i), 32'(valid_o), 32'h0);
      check($sformatf("v%0d_busy_end", i), 32'(busy_o), 32'h0);
      check($sformatf("v%0d_cs_end", i), 32'(cs_o), 32'h1);
      prev_data = vecs[i].exp_data;
    end

    // Reset during dclk pulse 12 aborts the frame with no late valid.
    cur_frame = 25'h1A5C3F0;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    rises = 0;
    prev_d = 1'b0;
    hit = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk_i);
      if (dclk_o && !prev_d) rises++;
      prev_d = dclk_o;
      if (rises == 12) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reached_pulse12", 32'(hit), 32'h1);
    rst_i = 1'b1;
    #1;
    check("abort_cs",   32'(cs_o),   32'h1);
    check("abort_dclk", 32'(dclk_o), 32'h0);
    check("abort_data", 32'(data_o), 32'h0);
    check("abort_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    valids = 0;
    falls = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_i);
      if (valid_o) valids++;
      if (!cs_o) falls++;
    end
    check("abort_no_valid", 32'(valids), 32'h0);
    check("abort_cs_idle",  32'(falls),  32'h0);
    check("abort_data_kept", 32'(data_o), 32'h0);

    // start_i held high: exactly two back-to-back frames, restart one cycle after DONE.
    cur_frame = 25'h03C3C3C;
    start_i = 1'b1;
    @(posedge clk_i);
    valids = 0;
    falls = 0;
    second_cyc = -1;
    v1_cyc = -1;
    v2_cyc = -1;
    v2_data = '0;
    prev_cs = 1'b0;
    for (int c = 1; c <= 450; c++) begin
      @(negedge clk_i);
      if (c == 300) start_i = 1'b0;
      if (!cs_o && prev_cs) begin
        falls++;
        if (falls == 1) second_cyc = c;
      end
      prev_cs = cs_o;
      if (valid_o) begin
        valids++;
        if (valids == 1) v1_cyc = c;
        if (valids == 2) begin
          v2_cyc = c;
          v2_data = data_o;
        end
      end
    end
    check("b2b_restarts",   32'(falls),      32'd1);
    check("b2b_second_cyc", 32'(second_cyc), 32'd207);
    check("b2b_valids",     32'(valids),     32'd2);
    check("b2b_v1_cyc",     32'(v1_cyc),     32'd205);
    check("b2b_v2_cyc",     32'(v2_cyc),     32'd411);
    check("b2b_v2_data",    32'(v2_data),    32'h3C3C3C);
    check("b2b_idle_busy",  32'(busy_o),     32'h0);
`else
    // Ready arrives late: clocking starts DIV cycles after miso falls.
    manual = 1'b1;
    miso_man = 1'b1;
    cur_frame = 25'h0C0FFEE;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    lat = -1;
    first_rise = -1;
    prev_d = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk_i);
      if (c == 54) manual = 1'b0;
      if (dclk_o && !prev_d && first_rise < 0) first_rise = c;
      prev_d = dclk_o;
      if (valid_o) begin
        lat = c;
        break;
      end
    end
    check("rdy_first_rise", 32'(first_rise), 32'd59);
    check("rdy_latency",    32'(lat),        32'd255);
    check("rdy_data",       32'(data_o),     32'hC0FFEE);
    @(negedge clk_i);
    check("rdy_busy_end", 32'(busy_o), 32'h0);

    // miso never signals ready: timeout error, no clocking, data kept.
    manual = 1'b1;
    miso_man = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    errs = 0;
    err_cyc = -1;
    rises = 0;
    valids = 0;
    prev_d = 1'b0;
    for (int c = 1; c <= 1200; c++) begin
      @(negedge clk_i);
      if (dclk_o && !prev_d) rises++;
      prev_d = dclk_o;
      if (valid_o) valids++;
      if (err_o) begin
        errs++;
        if (err_cyc < 0) err_cyc = c;
      end
    end
    check("tmo_err_count", 32'(errs),    32'd1);
    check("tmo_err_cyc",   32'(err_cyc), 32'd1029);
    check("tmo_no_dclk",   32'(rises),   32'd0);
    check("tmo_no_valid",  32'(valids),  32'd0);
    check("tmo_cs_high",   32'(cs_o),    32'h1);
    check("tmo_data_kept", 32'(data_o),  32'hC0FFEE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
